// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//
// Main control FSM and ALU decoder for the multicycle MIPS core. It sequences the
// shared-memory datapath through the fetch, decode, execute, memory and writeback
// steps, and drives every mux select, write enable and the ALU control. Memory steps
// wait on the mem_ready handshake, so a variable-latency memory stalls the FSM.
//
// Parameters
//   USE_MEM_READY  1 = memory steps wait for mem_ready, 0 = mem_ready treated as 1
//   STATE_W        width of the state register and the state debug output (>= 4)
//
// Optional feature
//   MIPS_CTRL_BNE_EN  when defined, op 000101 (bne) decodes to BNEEX (encoding 12);
//                     otherwise bne is an unknown op and executes as a NOP.
//
// Ports
//   clk, reset           clock; synchronous active-high reset forcing FETCH
//   op, funct            opcode and funct fields from the instruction register
//   zero                 ALU zero flag (branch condition)
//   mem_ready            memory has completed the current read or write
//   memwrite, iord       memory write strobe, memory address select (0 PC, 1 ALUOut)
//   irwrite              instruction register load
//   regdst, memtoreg     register destination / write-data selects
//   regwrite             register file write enable
//   alusrca, alusrcb     ALU operand selects
//   pcsrc, pcen          PC source select and PC load enable
//   alucontrol           ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   state                current state, for debug

module mips_multicycle_ctrl #(
    parameter int unsigned USE_MEM_READY = 1,
    parameter int unsigned STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        StFetch   = STATE_W'(0),
        StDecode  = STATE_W'(1),
        StMemAdr  = STATE_W'(2),
        StMemRd   = STATE_W'(3),
        StMemWb   = STATE_W'(4),
        StMemWr   = STATE_W'(5),
        StRtypeEx = STATE_W'(6),
        StRtypeWb = STATE_W'(7),
        StBeqEx   = STATE_W'(8),
        StAddiEx  = STATE_W'(9),
        StAddiWb  = STATE_W'(10),
`ifdef MIPS_CTRL_BNE_EN
        StJEx     = STATE_W'(11),
        StBneEx   = STATE_W'(12)
`else
        StJEx     = STATE_W'(11)
`endif
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    state_e state_q, state_d;

    logic mem_ok;       // memory step may complete this cycle
    logic pcwrite;      // unconditional PC load
    logic branch;       // conditional PC load
    logic taken;        // branch condition for the current branch state
    logic irwrite_raw;

    assign mem_ok = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Next-state logic
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:   state_d = mem_ok ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
`ifdef MIPS_CTRL_BNE_EN
                    OpBne:      state_d = StBneEx;
`endif
                    // Unknown op: PC already advanced in FETCH, so it acts as a NOP.
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = mem_ok ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = mem_ok ? StFetch : StMemWr;
            StRtypeEx: state_d = StRtypeWb;
            StRtypeWb: state_d = StFetch;
            StBeqEx:   state_d = StFetch;
            StAddiEx:  state_d = StAddiWb;
            StAddiWb:  state_d = StFetch;
            StJEx:     state_d = StFetch;
`ifdef MIPS_CTRL_BNE_EN
            StBneEx:   state_d = StFetch;
`endif
            default:   state_d = StFetch;
        endcase
    end

    // Output decode
    always_comb begin
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite_raw = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        taken       = 1'b0;
        alucontrol  = AluAdd;
        case (state_q)
            StFetch: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_ok;
                pcwrite     = mem_ok;
            end
            StDecode: begin
                alusrcb = 2'b11;
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: begin
                iord = 1'b1;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alucontrol = AluAdd;
                    6'b100010: alucontrol = AluSub;
                    6'b100100: alucontrol = AluAnd;
                    6'b100101: alucontrol = AluOr;
                    6'b101010: alucontrol = AluSlt;
                    default:   alucontrol = AluAdd;
                endcase
            end
            StRtypeWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca    = 1'b1;
                alucontrol = AluSub;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                taken      = zero;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StAddiWb: begin
                regwrite = 1'b1;
            end
            StJEx: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            StBneEx: begin
                alusrca    = 1'b1;
                alucontrol = AluSub;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                taken      = ~zero;
            end
`endif
            default: begin
                // Unused encodings: everything stays 0, including alucontrol.
                alucontrol = 3'b000;
            end
        endcase
    end

    // Reset also blocks the PC and IR loads while FETCH is being forced.
    assign irwrite = irwrite_raw & ~reset;
    assign pcen    = (pcwrite | (branch & taken)) & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (default parameters).
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int rw_seen = 0;
    bit rw_mon = 1'b0;

    mips_multicycle_ctrl #(
        .USE_MEM_READY(1),
        .STATE_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .memwrite  (memwrite),
        .iord      (iord),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .pcen      (pcen),
        .alucontrol(alucontrol),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts regwrite pulses while the reset-during-stall scenario runs.
    always @(negedge clk) begin
        if (rw_mon && regwrite) rw_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held 2 cycles; PC/IR loads are blocked meanwhile.
        tick();
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_irwrite", 32'(irwrite), 0);
        check("rst_pcen", 32'(pcen), 0);
        reset = 1'b0;
        op    = 6'b100011;
        #1;
        check("fetch_state", 32'(state), 0);
        check("fetch_irwrite", 32'(irwrite), 1);
        check("fetch_pcen", 32'(pcen), 1);
        check("fetch_alusrcb", 32'(alusrcb), 1);
        check("fetch_memwrite", 32'(memwrite), 0);

        // lw: 0,1,2,3,4,0
        tick(); check("lw_decode", 32'(state), 1);
        check("dec_alusrcb", 32'(alusrcb), 3);
        tick(); check("lw_memadr", 32'(state), 2);
        check("memadr_srca", 32'(alusrca), 1);
        check("memadr_srcb", 32'(alusrcb), 2);
        tick(); check("lw_memrd", 32'(state), 3);
        check("memrd_iord", 32'(iord), 1);
        tick(); check("lw_memwb", 32'(state), 4);
        check("memwb_regwrite", 32'(regwrite), 1);
        check("memwb_memtoreg", 32'(memtoreg), 1);
        check("memwb_regdst", 32'(regdst), 0);
        tick(); check("lw_done", 32'(state), 0);

        // sw with 3 stalled MEMWR cycles
        op = 6'b101011;
        tick(); check("sw_decode", 32'(state), 1);
        tick(); check("sw_memadr", 32'(state), 2);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_memwr_state%0d", i), 32'(state), 5);
            check($sformatf("sw_memwrite%0d", i), 32'(memwrite), 1);
            check($sformatf("sw_iord%0d", i), 32'(iord), 1);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        check("sw_done", 32'(state), 0);
        check("sw_done_memwrite", 32'(memwrite), 0);

        // R-type slt, plus the rest of the funct decode
        op    = 6'b000000;
        funct = 6'b101010;
        tick(); check("r_decode", 32'(state), 1);
        tick(); check("r_ex", 32'(state), 6);
        #1;
        check("r_slt", 32'(alucontrol), 3'b111);
        check("r_srca", 32'(alusrca), 1);
        check("r_srcb", 32'(alusrcb), 0);
        funct = 6'b100000; #1; check("r_add", 32'(alucontrol), 3'b010);
        funct = 6'b100010; #1; check("r_sub", 32'(alucontrol), 3'b110);
        funct = 6'b100100; #1; check("r_and", 32'(alucontrol), 3'b000);
        funct = 6'b100101; #1; check("r_or", 32'(alucontrol), 3'b001);
        funct = 6'b111111; #1; check("r_unk", 32'(alucontrol), 3'b010);
        tick(); check("r_wb", 32'(state), 7);
        check("r_wb_regwrite", 32'(regwrite), 1);
        check("r_wb_regdst", 32'(regdst), 1);
        check("r_wb_alu", 32'(alucontrol), 3'b010);
        tick(); check("r_done", 32'(state), 0);

        // beq, taken then not taken
        op   = 6'b000100;
        zero = 1'b1;
        tick(); check("beq_decode", 32'(state), 1);
        tick(); check("beq_ex", 32'(state), 8);
        check("beq_pcen_t", 32'(pcen), 1);
        check("beq_pcsrc", 32'(pcsrc), 1);
        check("beq_alu", 32'(alucontrol), 3'b110);
        zero = 1'b0; #1;
        check("beq_pcen_nt", 32'(pcen), 0);
        tick(); check("beq_done", 32'(state), 0);

        // bne
        op = 6'b000101;
        tick(); check("bne_decode", 32'(state), 1);
        tick();
`ifdef MIPS_CTRL_BNE_EN
        check("bne_ex", 32'(state), 12);
        check("bne_pcen", 32'(pcen), 1);
        tick(); check("bne_done", 32'(state), 0);
`else
        check("bne_as_nop", 32'(state), 0);
`endif

        // j
        op = 6'b000010;
        tick(); check("j_decode", 32'(state), 1);
        tick(); check("j_ex", 32'(state), 11);
        check("j_pcen", 32'(pcen), 1);
        check("j_pcsrc", 32'(pcsrc), 2);
        tick(); check("j_done", 32'(state), 0);

        // addi
        op = 6'b001000;
        tick(); check("addi_decode", 32'(state), 1);
        tick(); check("addi_ex", 32'(state), 9);
        check("addi_srcb", 32'(alusrcb), 2);
        tick(); check("addi_wb", 32'(state), 10);
        check("addi_regwrite", 32'(regwrite), 1);
        check("addi_regdst", 32'(regdst), 0);
        check("addi_memtoreg", 32'(memtoreg), 0);
        tick(); check("addi_done", 32'(state), 0);

        // unknown op: 2 cycles
        op = 6'b111111;
        tick(); check("unk_decode", 32'(state), 1);
        tick(); check("unk_done", 32'(state), 0);

        // FETCH stall
        mem_ready = 1'b0; #1;
        check("fstall_irwrite", 32'(irwrite), 0);
        check("fstall_pcen", 32'(pcen), 0);
        tick(); check("fstall_state", 32'(state), 0);
        mem_ready = 1'b1;

        // reset during stalled MEMRD
        op = 6'b100011;
        rw_mon = 1'b1;
        tick(); check("rr_decode", 32'(state), 1);
        tick(); check("rr_memadr", 32'(state), 2);
        mem_ready = 1'b0;
        tick(); check("rr_memrd", 32'(state), 3);
        tick(); check("rr_memrd_stall", 32'(state), 3);
        reset = 1'b1;
        tick(); check("rr_state", 32'(state), 0);
        check("rr_pcen", 32'(pcen), 0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        op        = 6'b111111;
        tick(); check("rr_release", 32'(state), 1);
        rw_mon = 1'b0;
        check("rr_no_regwrite", 32'(rw_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM and ALU decoder for the multicycle MIPS core.
- Sequences the shared-memory datapath through fetch, decode, execute, memory and writeback steps.
- Issues all mux selects, write enables and ALU control.
- Memory accesses follow a ready handshake, so variable-latency memory stalls the FSM.

Parameters:
USE_MEM_READY, 1, 1 = memory steps wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
STATE_W, 4, width of the state register and the state debug output (minimum 4).

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high; forces FETCH
op  in  6  instruction opcode, from the instruction register
funct  in  6  instruction funct field
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current read or write
memwrite  out  1  memory write strobe
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  out  1  instruction register load
regdst  out  1  register destination select: 0 = rt, 1 = rd
memtoreg  out  1  register write data select: 0 = ALUOut, 1 = data register
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcen  out  1  PC load = pcwrite OR (branch AND taken)
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  STATE_W  current state, for debug and the bench

Behaviour:
Outputs
- Moore outputs are decoded combinationally from the state register.
- Exceptions: pcen, irwrite and the RTYPEEX alucontrol also depend on inputs, as stated below.
- Every output not listed for a state is 0 in that state.
- alucontrol is 010 in every state except RTYPEEX and BEQEX.

State encoding and per-state behaviour
- FETCH(0): iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010. irwrite and pcwrite are each asserted only when mem_ready=1 (gated by mem_ready). Goes to DECODE when mem_ready=1, otherwise stays.
- DECODE(1): alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JEX
  - any other op -> FETCH; the instruction executes as a NOP with PC already advanced.
- MEMADR(2): alusrca=1, alusrcb=10. Goes to MEMRD if op=100011, otherwise MEMWR.
- MEMRD(3): iord=1. Goes to MEMWB when mem_ready=1, otherwise stays.
- MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR(5): iord=1, memwrite=1, held until mem_ready=1; then goes to FETCH. memwrite deasserts in FETCH.
- RTYPEEX(6): alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - any other funct -> 010
  - Goes to RTYPEWB.
- RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BEQEX(8): alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1, so pcen=zero. Goes to FETCH.
- ADDIEX(9): alusrca=1, alusrcb=10. Goes to ADDIWB.
- ADDIWB(10): regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX(11): pcsrc=10, pcwrite=1. Goes to FETCH.
- Unused encodings: go to FETCH on the next edge; all outputs 0.

Latency with mem_ready always 1
- lw 5 cycles; sw, R-type and addi 4; beq and j 3; unknown op 2.
- Each stalled memory cycle adds 1 cycle.

Reset
- reset=1 at any edge, including mid-instruction or while stalled, loads FETCH.
- reset has priority over all other next-state conditions.
- While reset is held, irwrite and pcen are additionally forced to 0.
- After reset release, outputs match FETCH.

USE_MEM_READY=0: every memory step completes in 1 cycle.

Optional Feature:
Macro: MIPS_CTRL_BNE_EN
- Defined: op 000101 (bne) is decoded in DECODE and goes to a BNEEX(12) state. BNEEX drives the same outputs as BEQEX except pcen = NOT zero.
- Not defined: op 000101 takes the unknown-op path (DECODE -> FETCH); encoding 12 is unused.

Test Plan:
reset held 2 cycles then released, mem_ready=1 -> state=0, irwrite=1, pcen=1, alusrcb=01, memwrite=0 in the first cycle; state=1 on the next edge.
lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; MEMWB has regwrite=1 and memtoreg=1; 5 cycles total.
sw (op=101011), mem_ready low for 3 cycles in MEMWR -> memwrite=1 and iord=1 for 4 cycles, then state=0 and memwrite=0.
R-type funct=101010 -> alucontrol=111 in RTYPEEX; regwrite=1 and regdst=1 in RTYPEWB.
beq with zero=1 -> pcen=1 and pcsrc=01 in BEQEX; repeated with zero=0 -> pcen=0; op=000101 -> BNEEX only when MIPS_CTRL_BNE_EN is defined, otherwise DECODE goes to FETCH.
reset asserted in MEMRD while stalled -> state=0 on the next edge; no regwrite pulse ever seen.
